adc_fifo_byte_unpacker: RTL and testbench

Read-side stage between the slow ADC sample FIFO and the ADC register block on clk_usb. Each byte-request pulse from the register block (fifo_rd_en, issued on an ADCREAD_ADDR read) yields one output byte. Bytes are unpacked from 36-bit FIFO words, each holding three 12-bit samples, and formatted per low_res/low_res_lsb. The block prefetches words, and counts underflows and pops for the register block's status and debug registers.

---
 rtl/adc_fifo_byte_unpacker.sv | 181 ++++++++++++++++++
 tb/tb_adc_fifo_byte_unpacker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fifo_byte_unpacker.sv
// ---------------------------------------------------------------------------
// adc_fifo_byte_unpacker
//
// Read-side stage between the ADC sample FIFO and the ADC register block.
// Every byte request yields exactly one output byte. Bytes are unpacked from
// 36-bit FIFO words (three 12-bit samples, sample 0 in the low bits). A word
// is prefetched as soon as the FIFO has one, so most requests are answered
// on the next cycle.
//
// Ports:
//   clk_usb             clock; all logic is synchronous to it
//   reset               synchronous, active-high reset
//   byte_req            one-cycle byte request (>= 2 cycles apart)
//   low_res             1 = one byte per sample, 0 = two bytes per sample
//   low_res_lsb         low-res only: 1 = s[7:0], 0 = s[11:4]
//   no_underflow_errors 1 = underflows are counted but do not set the flag
//   clear_fifo_errors   level; clears underflow_count/underflow_error
//   flush               one-cycle pulse; drops held/prefetched data
//   fifo_dout           FIFO read data, valid the cycle after fifo_pop
//   fifo_empty          FIFO empty flag
//   fifo_pop            FIFO read enable
//   byte_out            current output byte, held until the next response
//   byte_valid          one-cycle strobe marking a new byte_out
//   underflow_count     saturating count of requests served with no data
//   underflow_error     sticky underflow flag
//   fifo_pop_count      words popped since reset/flush (wraps)
// ---------------------------------------------------------------------------
module adc_fifo_byte_unpacker #(
    parameter int pSAMPLE_BITS      = 12,
    parameter int pSAMPLES_PER_WORD = 3
) (
    input  logic                                      clk_usb,
    input  logic                                      reset,
    input  logic                                      byte_req,
    input  logic                                      low_res,
    input  logic                                      low_res_lsb,
    input  logic                                      no_underflow_errors,
    input  logic                                      clear_fifo_errors,
    input  logic                                      flush,
    input  logic [pSAMPLE_BITS*pSAMPLES_PER_WORD-1:0] fifo_dout,
    input  logic                                      fifo_empty,
    output logic                                      fifo_pop,
    output logic [7:0]                                byte_out,
    output logic                                      byte_valid,
    output logic [7:0]                                underflow_count,
    output logic                                      underflow_error,
    output logic [31:0]                               fifo_pop_count
);

    localparam int WORD_W = pSAMPLE_BITS * pSAMPLES_PER_WORD;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] LOADED = 2'd2;

    logic [1:0]        state;
    logic [2:0]        byte_idx;
    logic              pending;
    logic [WORD_W-1:0] hold_word;
    logic              word_low_res;
    logic              word_lsb;

    logic              serve_loaded;
    logic              last_byte;
    logic [2:0]        last_idx;
    logic              underflow;

    // Byte idx of a word in the given mode. Low-res: one byte per sample.
    // Full-res: high nibble (zero-extended) first, then the low byte.
    function automatic logic [7:0] sel_byte(input logic [WORD_W-1:0] w,
                                            input logic [2:0]        idx,
                                            input logic              lr,
                                            input logic              lsb);
        logic [2:0]              k;
        logic [pSAMPLE_BITS-1:0] s;
        k = lr ? idx : {1'b0, idx[2:1]};
        s = pSAMPLE_BITS'(w >> (k * pSAMPLE_BITS));
        if (lr)
            return lsb ? s[7:0] : s[11:4];
        return idx[0] ? s[7:0] : {4'b0000, s[11:8]};
    endfunction

    assign last_idx     = word_low_res ? 3'(pSAMPLES_PER_WORD - 1)
                                       : 3'(2 * pSAMPLES_PER_WORD - 1);
    // A request that arrived during FETCH is served from LOADED one cycle later.
    assign serve_loaded = (state == LOADED) && (pending || byte_req);
    assign last_byte    = serve_loaded && (byte_idx == last_idx);
    assign underflow    = !flush && (state == IDLE) && fifo_empty && byte_req;

    // Pop is combinational so the next word is requested in the same cycle
    // the last byte of the current word is requested.
    assign fifo_pop = !reset && !flush && !fifo_empty &&
                      ((state == IDLE) || last_byte);

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state           <= IDLE;
            byte_idx        <= 3'd0;
            pending         <= 1'b0;
            byte_out        <= 8'h00;
            byte_valid      <= 1'b0;
            underflow_count <= 8'h00;
            underflow_error <= 1'b0;
            fifo_pop_count  <= 32'd0;
        end else begin
            byte_valid <= 1'b0;
            if (fifo_pop)
                fifo_pop_count <= fifo_pop_count + 32'd1;

            if (flush) begin
                // Returning to IDLE also drops a word landing from a pop
                // issued in the previous cycle.
                state          <= IDLE;
                byte_idx       <= 3'd0;
                pending        <= 1'b0;
                fifo_pop_count <= 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            state   <= FETCH;
                            pending <= byte_req;
                        end else if (byte_req) begin
                            byte_out   <= 8'h00;
                            byte_valid <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state <= LOADED;
                        if (pending) begin
                            // Request arrived while idle: serve byte 0
                            // straight from the landing word.
                            byte_out   <= sel_byte(fifo_dout, 3'd0, low_res, low_res_lsb);
                            byte_valid <= 1'b1;
                            byte_idx   <= 3'd1;
                            pending    <= 1'b0;
                        end else begin
                            byte_idx <= 3'd0;
                            pending  <= byte_req;
                        end
                    end
                    LOADED: begin
                        if (serve_loaded) begin
                            byte_out   <= sel_byte(hold_word, byte_idx, word_low_res, word_lsb);
                            byte_valid <= 1'b1;
                            pending    <= 1'b0;
                            if (last_byte) begin
                                byte_idx <= 3'd0;
                                state    <= fifo_empty ? IDLE : FETCH;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Clear wins over an underflow in the same cycle.
            if (clear_fifo_errors) begin
                underflow_count <= 8'h00;
                underflow_error <= 1'b0;
            end else if (underflow) begin
                if (underflow_count != 8'hFF)
                    underflow_count <= underflow_count + 8'd1;
                if (!no_underflow_errors)
                    underflow_error <= 1'b1;
            end
        end
    end

    // Holding word and its mode: captured as the popped word lands.
    always_ff @(posedge clk_usb) begin
        if (state == FETCH && !flush) begin
            hold_word    <= fifo_dout;
            word_low_res <= low_res;
            word_lsb     <= low_res_lsb;
        end
    end

endmodule

// File: tb/tb_adc_fifo_byte_unpacker.sv
// ---------------------------------------------------------------------------
// tb_adc_fifo_byte_unpacker
//
// Drives adc_fifo_byte_unpacker from a behavioural non-FWFT FIFO and checks
// every returned byte, its latency and the status counters against a
// byte-stream reference model.
// ---------------------------------------------------------------------------
module tb_adc_fifo_byte_unpacker;

    logic        clk_usb = 1'b0;
    logic        reset;
    logic        byte_req;
    logic        low_res;
    logic        low_res_lsb;
    logic        no_underflow_errors;
    logic        clear_fifo_errors;
    logic        flush;
    logic [35:0] fifo_dout = 36'd0;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [7:0]  underflow_count;
    logic        underflow_error;
    logic [31:0] fifo_pop_count;

    always #5 clk_usb = ~clk_usb;

    adc_fifo_byte_unpacker dut (
        .clk_usb             (clk_usb),
        .reset               (reset),
        .byte_req            (byte_req),
        .low_res             (low_res),
        .low_res_lsb         (low_res_lsb),
        .no_underflow_errors (no_underflow_errors),
        .clear_fifo_errors   (clear_fifo_errors),
        .flush               (flush),
        .fifo_dout           (fifo_dout),
        .fifo_empty          (fifo_empty),
        .fifo_pop            (fifo_pop),
        .byte_out            (byte_out),
        .byte_valid          (byte_valid),
        .underflow_count     (underflow_count),
        .underflow_error     (underflow_error),
        .fifo_pop_count      (fifo_pop_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk_usb) cyc <= cyc + 1;

    // Behavioural FIFO: read data appears the cycle after the pop.
    logic [35:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk_usb) begin
        if (fifo_pop) begin
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Output monitor.
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    int         pop_viol = 0;
    always @(negedge clk_usb) begin
        if (byte_valid) begin
            got_q.push_back(byte_out);
            got_cyc_q.push_back(cyc);
        end
        if (fifo_pop && fifo_empty) pop_viol++;
    end

    // Reference model: the stream of bytes not yet delivered, plus counters.
    logic [7:0] avail_q[$];
    logic [7:0] exp_q[$];
    int         req_cyc_q[$];
    int         lat_q[$];
    int         chk_idx  = 0;
    int         m_uf_cnt = 0;
    bit         m_uf_err = 0;
    int         pops_exp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_push_bytes(input logic [35:0] w, input bit lr, input bit lsb);
        for (int k = 0; k < 3; k++) begin
            int s;
            s = int'((w >> (12 * k)) & 36'hFFF);
            if (lr) begin
                avail_q.push_back(lsb ? 8'(s % 256) : 8'(s / 16));
            end else begin
                avail_q.push_back(8'(s / 256));
                avail_q.push_back(8'(s % 256));
            end
        end
    endfunction

    // lr/lsb: the mode in force when the unpacker latches this word.
    task automatic push_word(input logic [35:0] w, input bit lr, input bit lsb);
        mem[wr_ptr % 1024] = w;
        wr_ptr++;
        pops_exp++;
        model_push_bytes(w, lr, lsb);
    endtask

    task automatic req(input int gap, input int exp_lat, input int pop_exp);
        logic [7:0] e;
        if (avail_q.size() > 0) begin
            e = avail_q.pop_front();
        end else begin
            e = 8'h00;
            if (clear_fifo_errors) begin
                m_uf_cnt = 0;
                m_uf_err = 0;
            end else begin
                if (m_uf_cnt < 255) m_uf_cnt++;
                if (!no_underflow_errors) m_uf_err = 1;
            end
        end
        exp_q.push_back(e);
        req_cyc_q.push_back(cyc);
        lat_q.push_back(exp_lat);
        byte_req = 1'b1;
        if (pop_exp >= 0) begin
            #1;
            check("pop_with_req", fifo_pop, pop_exp);
        end
        @(negedge clk_usb);
        byte_req = 1'b0;
        repeat (gap - 1) @(negedge clk_usb);
    endtask

    task automatic clear_errors();
        clear_fifo_errors = 1'b1;
        @(negedge clk_usb);
        clear_fifo_errors = 1'b0;
        m_uf_cnt = 0;
        m_uf_err = 0;
    endtask

    task automatic check_all(input string tag);
        int lat;
        repeat (4) @(negedge clk_usb);
        while (chk_idx < exp_q.size()) begin
            if (chk_idx < got_q.size()) begin
                check({tag, "_byte"}, got_q[chk_idx], exp_q[chk_idx]);
                lat = got_cyc_q[chk_idx] - req_cyc_q[chk_idx];
                check({tag, "_latency"}, lat, lat_q[chk_idx]);
            end else begin
                check({tag, "_missing"}, got_q.size(), exp_q.size());
            end
            chk_idx++;
        end
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        check({tag, "_uf_count"}, underflow_count, m_uf_cnt);
        check({tag, "_uf_error"}, underflow_error, m_uf_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [35:0] w;
        bit          lr;
        bit          lsb;

        reset = 1'b1; byte_req = 1'b0; low_res = 1'b0; low_res_lsb = 1'b0;
        no_underflow_errors = 1'b0; clear_fifo_errors = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk_usb);
        check("rst_fifo_pop", fifo_pop, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_uf_count", underflow_count, 0);
        check("rst_uf_error", underflow_error, 0);
        check("rst_pop_count", fifo_pop_count, 0);
        reset = 1'b0;

        // Full res; request issued together with the push (served from IDLE).
        push_word(36'hABC_123_456, 0, 0);
        req(3, 2, -1);
        repeat (5) req(3, 1, -1);
        check_all("full_res");
        check("full_res_pops", fifo_pop_count, pops_exp);

        // Request issued while the word is still in FETCH.
        push_word(36'($urandom) ^ (36'($urandom) << 4), 0, 0);
        @(negedge clk_usb);
        req(3, 2, -1);
        repeat (5) req(3, 1, -1);
        check_all("fetch_req");
        check("fetch_req_pops", fifo_pop_count, pops_exp);

        // Low res MSBs; mode flipped mid-word only affects the next word.
        low_res = 1'b1; low_res_lsb = 1'b0;
        push_word(36'hABC_123_456, 1, 0);
        push_word(36'($urandom) ^ (36'($urandom) << 4), 0, 0);
        repeat (3) @(negedge clk_usb);
        req(3, 1, -1);
        low_res = 1'b0;
        repeat (2) req(3, 1, -1);
        repeat (6) req(3, 1, -1);
        low_res = 1'b1; low_res_lsb = 1'b1;
        push_word(36'hABC_123_456, 1, 1);
        repeat (3) @(negedge clk_usb);
        repeat (3) req(3, 1, -1);
        check_all("low_res");
        check("low_res_pops", fifo_pop_count, pops_exp);

        // Two queued words, 2-cycle request spacing.
        low_res = 1'b0; low_res_lsb = 1'b0;
        push_word(36'($urandom) ^ (36'($urandom) << 4), 0, 0);
        push_word(36'($urandom) ^ (36'($urandom) << 4), 0, 0);
        repeat (3) @(negedge clk_usb);
        for (int i = 0; i < 12; i++)
            req(2, 1, (i == 5) ? 1 : ((i == 11) ? 0 : -1));
        check_all("two_words");
        check("two_words_pops", fifo_pop_count, pops_exp);

        // Underflow saturation, error masking and clear priority.
        repeat (300) req(2, 1, -1);
        check_all("underflow");
        clear_errors();
        check("uf_clear_cnt", underflow_count, 0);
        check("uf_clear_err", underflow_error, 0);
        no_underflow_errors = 1'b1;
        repeat (300) req(2, 1, -1);
        check_all("uf_masked");
        no_underflow_errors = 1'b0;
        clear_errors();
        check_all("uf_cleared");
        clear_fifo_errors = 1'b1;
        req(2, 1, -1);
        clear_fifo_errors = 1'b0;
        check_all("uf_clear_prio");
        req(2, 1, -1);
        check_all("uf_single");
        clear_errors();

        // Flush mid-word, then a fresh word.
        push_word(36'hABC_123_456, 0, 0);
        repeat (3) @(negedge clk_usb);
        repeat (2) req(3, 1, -1);
        flush = 1'b1;
        @(negedge clk_usb);
        flush = 1'b0;
        avail_q.delete();
        pops_exp = 0;
        check("flush_pop_count", fifo_pop_count, 0);
        push_word(36'h111_222_333, 0, 0);
        repeat (3) @(negedge clk_usb);
        repeat (6) req(3, 1, -1);
        check_all("flush");
        check("flush_pops", fifo_pop_count, 1);

        // Flush while a word is landing: that word is dropped.
        push_word(36'($urandom), 0, 0);
        @(negedge clk_usb);
        flush = 1'b1;
        @(negedge clk_usb);
        flush = 1'b0;
        avail_q.delete();
        pops_exp = 0;
        req(3, 1, -1);
        check_all("flush_landing");
        check("flush_landing_pops", fifo_pop_count, 0);

        // Reset during FETCH.
        push_word(36'hABC_123_456, 0, 0);
        repeat (3) @(negedge clk_usb);
        repeat (6) req(3, 1, -1);
        check_all("pre_reset");
        push_word(36'h5A5_A5A_F0F, 0, 0);
        @(negedge clk_usb);
        reset = 1'b1;
        @(negedge clk_usb);
        check("rst2_fifo_pop", fifo_pop, 0);
        check("rst2_byte_out", byte_out, 0);
        check("rst2_byte_valid", byte_valid, 0);
        check("rst2_uf_count", underflow_count, 0);
        check("rst2_uf_error", underflow_error, 0);
        check("rst2_pop_count", fifo_pop_count, 0);
        reset = 1'b0;
        avail_q.delete();
        m_uf_cnt = 0; m_uf_err = 0; pops_exp = 0;
        push_word(36'h876_543_210, 0, 0);
        repeat (3) @(negedge clk_usb);
        repeat (6) req(3, 1, -1);
        check_all("post_reset");
        check("post_reset_pops", fifo_pop_count, pops_exp);

        // Randomized words and modes.
        for (int n = 0; n < 10; n++) begin
            lr  = 1'($urandom);
            lsb = 1'($urandom);
            w   = 36'($urandom) ^ (36'($urandom) << 4);
            low_res = lr; low_res_lsb = lsb;
            push_word(w, lr, lsb);
            repeat (3) @(negedge clk_usb);
            repeat (lr ? 3 : 6) req(int'($urandom_range(2, 4)), 1, -1);
        end
        check_all("random");
        check("random_pops", fifo_pop_count, pops_exp);

        check("pop_while_empty", pop_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
